// File: rtl/shared_resource_pkg.sv
// Shared constants, state encoding and helpers for the weighted round-robin resource scheduler.
package shared_resource_pkg;

  localparam int unsigned NUM_REQ_DEF  = 4;
  localparam int unsigned WEIGHT_W_DEF = 4;
  localparam int unsigned HOLD_MAX_DEF = 8;
  localparam int unsigned MAX_REQ      = 16;
  localparam int unsigned MAX_W        = 16;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OWNED = 1'b1
  } sched_state_e;

  // A zero weight still grants one transfer per turn.
  function automatic logic [MAX_W-1:0] eff_weight(input logic [MAX_W-1:0] w);
    return (w == '0) ? MAX_W'(1) : w;
  endfunction

  function automatic logic [3:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/resource_scheduler_if.sv
// Requester-side signals of the scheduler: request/stall/flush/weights in, grant and fire out.
interface resource_scheduler_if
  import shared_resource_pkg::*;
#(
  parameter int unsigned NUM_REQ  = NUM_REQ_DEF,
  parameter int unsigned WEIGHT_W = WEIGHT_W_DEF
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ-1:0]          stall;
  logic [NUM_REQ-1:0]          flush;
  logic [NUM_REQ*WEIGHT_W-1:0] weight;
  logic [NUM_REQ-1:0]          grant;
  logic                        grant_valid;
  logic [ID_W-1:0]             grant_id;
  logic                        fire;

  modport master (
    output req, stall, flush, weight,
    input  grant, grant_valid, grant_id, fire
  );

  modport slave (
    input  req, stall, flush, weight,
    output grant, grant_valid, grant_id, fire
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating priority encoder: first candidate after i_last (with wrap), excluding masked lanes.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_elig,
  input  logic [$clog2(NUM_REQ)-1:0] i_last,
  input  logic [NUM_REQ-1:0]         i_exclude,
  output logic [NUM_REQ-1:0]         o_pick_c,
  output logic                       o_found_c
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] w_cand;
  logic [ID_W-1:0]    w_idx;

  assign w_cand = i_elig & ~i_exclude;

  always_comb begin
    o_pick_c  = '0;
    o_found_c = 1'b0;
    w_idx     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((32'(i_last) + k) % NUM_REQ);
      if (!o_found_c && w_cand[w_idx]) begin
        o_pick_c[w_idx] = 1'b1;
        o_found_c       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/resource_scheduler.sv
// Weighted round-robin owner of a shared resource with stall-bounded preemption.
module resource_scheduler
  import shared_resource_pkg::*;
#(
  parameter int unsigned NUM_REQ  = NUM_REQ_DEF,
  parameter int unsigned WEIGHT_W = WEIGHT_W_DEF,
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEF
) (
  input logic                 clk,
  input logic                 reset_n,
  resource_scheduler_if.slave bus
);
  localparam int unsigned ID_W     = $clog2(NUM_REQ);
  localparam int unsigned HC_W     = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
  localparam int unsigned HOLD_LIM = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;

  sched_state_e        r_state, w_state_nx;
  logic [NUM_REQ-1:0]  r_grant, w_grant_nx;
  logic [ID_W-1:0]     r_id, w_id_nx;
  logic [ID_W-1:0]     r_last, w_last_nx;
  logic [WEIGHT_W-1:0] r_credit, w_credit_nx;
  logic [HC_W-1:0]     r_hold, w_hold_nx;

  logic [NUM_REQ-1:0]  w_elig, w_pick, w_excl;
  logic [ID_W-1:0]     w_ptr, w_pick_id;
  logic [WEIGHT_W-1:0] w_wt [NUM_REQ];
  logic w_owned, w_found, w_own_req, w_own_stall, w_own_flush;
  logic w_fire, w_others, w_exhaust, w_preempt, w_release;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_wt[i] = WEIGHT_W'(eff_weight(MAX_W'(bus.weight[i*WEIGHT_W +: WEIGHT_W])));
    end
  end

  assign w_owned     = (r_state == S_OWNED);
  assign w_elig      = bus.req & ~bus.flush;
  assign w_own_req   = bus.req[r_id];
  assign w_own_stall = bus.stall[r_id];
  assign w_own_flush = bus.flush[r_id];
  assign w_fire      = w_owned & w_own_req & ~w_own_stall & ~w_own_flush;
  assign w_others    = |(w_elig & ~r_grant);
  assign w_exhaust   = w_fire && (r_credit == WEIGHT_W'(1));
  assign w_preempt   = (HOLD_MAX != 0) && (r_hold == HC_W'(HOLD_LIM)) && w_own_stall && w_others;
  assign w_release   = w_exhaust | ~w_own_req | w_own_flush | w_preempt;

  // While owned, scanning starts after the owner so the owner itself comes last.
  assign w_ptr  = w_owned ? r_id : r_last;
  assign w_excl = w_owned ? r_grant : '0;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_elig    (w_elig),
    .i_last    (w_ptr),
    .i_exclude (w_excl),
    .o_pick_c  (w_pick),
    .o_found_c (w_found)
  );

  assign w_pick_id = ID_W'(onehot_to_idx(MAX_REQ'(w_pick)));

  always_comb begin
    w_state_nx  = r_state;
    w_grant_nx  = r_grant;
    w_id_nx     = r_id;
    w_last_nx   = r_last;
    w_credit_nx = r_credit;
    w_hold_nx   = r_hold;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nx  = S_OWNED;
          w_grant_nx  = w_pick;
          w_id_nx     = w_pick_id;
          w_credit_nx = w_wt[w_pick_id];
          w_hold_nx   = '0;
        end
      end
      S_OWNED: begin
        if (w_release) begin
          w_last_nx = r_id;
          if (w_found) begin
            w_grant_nx  = w_pick;
            w_id_nx     = w_pick_id;
            w_credit_nx = w_wt[w_pick_id];
            w_hold_nx   = '0;
          end else if (w_elig[r_id] && w_exhaust) begin
            w_credit_nx = w_wt[r_id];
            w_hold_nx   = '0;
          end else begin
            w_state_nx  = S_IDLE;
            w_grant_nx  = '0;
            w_credit_nx = '0;
            w_hold_nx   = '0;
          end
        end else if (w_fire) begin
          w_credit_nx = r_credit - WEIGHT_W'(1);
          w_hold_nx   = '0;
        end else if (w_own_stall && w_own_req && (r_hold != HC_W'(HOLD_LIM))) begin
          // Saturates at the preemption threshold so a late waiter preempts at once.
          w_hold_nx = r_hold + HC_W'(1);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_id     <= '0;
      r_last   <= ID_W'(NUM_REQ - 1);
      r_credit <= '0;
      r_hold   <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_grant  <= w_grant_nx;
      r_id     <= w_id_nx;
      r_last   <= w_last_nx;
      r_credit <= w_credit_nx;
      r_hold   <= w_hold_nx;
    end
  end

  assign bus.grant       = r_grant;
  assign bus.grant_valid = |r_grant;
  assign bus.grant_id    = r_id;
  assign bus.fire        = w_fire;

endmodule
